// File: rtl/spi_pwm_pkg.sv
// Shared constants, FSM state type and SPI word builder for the PWM host controller.
package spi_pwm_pkg;

  localparam logic [7:0]  WRITE_FLAG   = 8'h80;
  localparam int unsigned NUM_CHANNELS = 7;
  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned LEVEL_W      = 8;
  localparam int unsigned XFER_BITS    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  // Command byte then data byte; reads carry a dummy 0x00 data byte.
  function automatic logic [XFER_BITS-1:0] build_word(input logic               write,
                                                      input logic [ADDR_W-1:0]  addr,
                                                      input logic [LEVEL_W-1:0] data);
    if (write) begin
      return {WRITE_FLAG | 8'(addr), data};
    end
    return {8'(addr), 8'h00};
  endfunction

endpackage

// File: rtl/spi_pwm_host_if.sv
// Command/response handshake between a host and the spi_pwm_host controller.
interface spi_pwm_host_if;
  import spi_pwm_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEVEL_W-1:0] cmd_data;
  logic               rsp_valid;
  logic [LEVEL_W-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/spi_pwm_host_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles, realigned by restart.
module spi_pwm_host_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_pwm_host.sv
// SPI controller turning one PWM-level read/write command into a 16-bit transfer.
// Optional SPI_PWM_HOST_VERIFY_WRITE_EN: each write is followed by a readback and compare.
module spi_pwm_host
  import spi_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  spi_pwm_host_if.slave bus,
  output logic          sclk,
  output logic          cs,
  output logic          mosi,
  input  logic          miso
);

  state_e               state_q, state_d;
  logic                 phase_hi_q, phase_hi_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [XFER_BITS-1:0] sh_q, sh_d;
  logic [LEVEL_W-1:0]   rx_q, rx_d;
  logic [LEVEL_W-1:0]   data_q, data_d;
  logic [LEVEL_W-1:0]   rsp_data_q, rsp_data_d;
  logic                 write_q, write_d;
  logic                 sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 idle, accept, tick, restart;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 readback_q, readback_d;
  logic                 rsp_err_q, rsp_err_d;
`endif

  assign idle    = (state_q == StIdle);
  assign accept  = bus.cmd_valid && idle;
  assign restart = (state_d != state_q);

  spi_pwm_host_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    phase_hi_d  = phase_hi_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    write_d     = write_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
    addr_d      = addr_q;
    readback_d  = readback_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (accept) begin
          state_d = StSetup;
          sh_d    = build_word(bus.cmd_write, bus.cmd_addr, bus.cmd_data);
          mosi_d  = sh_d[XFER_BITS-1];
          cs_d    = 1'b0;
          write_d = bus.cmd_write;
          data_d  = bus.cmd_data;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
          addr_d     = bus.cmd_addr;
          readback_d = 1'b0;
`endif
        end
      end
      StSetup: begin
        if (tick) begin
          state_d    = StShift;
          sclk_d     = 1'b1;
          phase_hi_d = 1'b1;
          bit_cnt_d  = 5'd1;
        end
      end
      StShift: begin
        if (tick) begin
          if (phase_hi_q) begin
            sclk_d     = 1'b0;
            phase_hi_d = 1'b0;
            sh_d       = sh_q << 1;
            mosi_d     = sh_q[XFER_BITS-2];
          end else if (bit_cnt_q == 5'd16) begin
            state_d = StHold;
          end else begin
            sclk_d     = 1'b1;
            phase_hi_d = 1'b1;
            bit_cnt_d  = bit_cnt_q + 5'd1;
            // Data-byte rises: peripheral returns the level LSB first.
            if (bit_cnt_q >= 5'd8) begin
              rx_d = {miso, rx_q[LEVEL_W-1:1]};
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StGap;
          cs_d    = 1'b1;
        end
      end
      StGap: begin
        if (tick) begin
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
          if (write_q && !readback_q) begin
            state_d    = StSetup;
            readback_d = 1'b1;
            sh_d       = build_word(1'b0, addr_q, '0);
            mosi_d     = sh_d[XFER_BITS-1];
            cs_d       = 1'b0;
          end else begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
            rsp_err_d   = readback_q && (rx_q != data_q);
          end
`else
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_data_d  = write_q ? data_q : rx_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_hi_q  <= 1'b0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      write_q     <= 1'b0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
      addr_q      <= '0;
      readback_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_hi_q  <= phase_hi_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      write_q     <= write_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
      addr_q      <= addr_d;
      readback_q  <= readback_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = idle;
  assign bus.busy      = !idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_pwm_host.sv
// Bench for spi_pwm_host: PWM peripheral pin model, reference model and response scoreboard.
module tb_spi_pwm_host;
  import spi_pwm_pkg::*;

  localparam int D    = 4;
  localparam int T    = 10;
  localparam int HALF = T / 2;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
  localparam int WR_LAT = 70 * D;
`else
  localparam int WR_LAT = 35 * D;
`endif
  localparam int RD_LAT = 35 * D;

  typedef struct {
    logic [7:0] data;
    logic       err;
    longint     t_acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk, cs, mosi;
  logic miso = 1'b0;

  spi_pwm_host_if bus ();

  spi_pwm_host #(
    .CLK_DIV(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .sclk (sclk),
    .cs   (cs),
    .mosi (mosi),
    .miso (miso)
  );

  always #(HALF) clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  exp_t        rsp_q[$];
  logic [15:0] xfer_q[$];
  logic [7:0]  m_regs[8];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- PWM peripheral pin model ----------------
  logic [7:0]  p_regs[8];
  logic [15:0] p_word;
  logic [7:0]  p_out;
  int          p_cnt = 0;
  longint      t_cs_rise = 0;
  bit          have_rise = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      p_regs[i] = 8'h00;
      m_regs[i] = 8'h00;
    end
    p_word = '0;
    p_out  = '0;
  end

  always @(negedge cs) begin
    if (have_rise) chk("cs_gap_ge_div", longint'(($time - t_cs_rise) >= D * T), 1);
    p_cnt  = 0;
    p_word = '0;
    p_out  = '0;
  end

  always @(posedge sclk) begin
    chk("cs_low_on_sclk_rise", cs, 1'b0);
    p_word = {p_word[14:0], mosi};
    p_cnt++;
    if (p_cnt == 8 && !p_word[7]) begin
      p_out = (p_word[2:0] < NUM_CHANNELS) ? p_regs[p_word[2:0]] : 8'h00;
    end
    if (p_cnt == 16 && p_word[15] && p_word[10:8] < NUM_CHANNELS) begin
      p_regs[p_word[10:8]] = p_word[7:0];
    end
  end

  always @(negedge sclk) begin
    if (cs == 1'b0 && p_cnt >= 8 && p_cnt < 16) miso = p_out[p_cnt-8];
  end

  always @(posedge cs) begin
    if (reset) begin
      have_rise = 0;
    end else begin
      if (xfer_q.size() == 0) begin
        chk("unexpected_transfer", 1, 0);
      end else begin
        logic [15:0] w;
        w = xfer_q.pop_front();
        chk("sclk_rises", p_cnt, 16);
        chk("mosi_word", p_word, w);
      end
      t_cs_rise = $time;
      have_rise = 1;
    end
  end

  // ---------------- response monitor ----------------
  logic prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      chk("rsp_single_cycle", prev_rsp, 1'b0);
      chk("ready_at_rsp", bus.cmd_ready, 1'b1);
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = rsp_q.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_latency", ($time - HALF - e.t_acc) / T, e.lat);
      end
    end
    prev_rsp = bus.rsp_valid;
  end

  // ---------------- reference model and driver ----------------
  function automatic exp_t model(bit w, logic [2:0] a, logic [7:0] d, longint t);
    exp_t e;
    e.t_acc = t;
    e.err   = 1'b0;
    if (w) begin
      if (a < NUM_CHANNELS) m_regs[a] = d;
      e.lat  = WR_LAT;
      e.data = d;
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
      e.data = (a < NUM_CHANNELS) ? m_regs[a] : 8'h00;
      e.err  = (e.data != d);
`endif
    end else begin
      e.lat  = RD_LAT;
      e.data = (a < NUM_CHANNELS) ? m_regs[a] : 8'h00;
    end
    return e;
  endfunction

  task automatic issue(input bit w, input logic [2:0] a, input logic [7:0] d, input bit keep,
                       output longint t_acc);
    int guard = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      t_acc = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    rsp_q.push_back(model(w, a, d, t_acc));
    if (w) begin
      xfer_q.push_back({8'h80 | {5'b0, a}, d});
`ifdef SPI_PWM_HOST_VERIFY_WRITE_EN
      xfer_q.push_back({5'b0, a, 8'h00});
`endif
    end else begin
      xfer_q.push_back({5'b0, a, 8'h00});
    end
    if (!keep) #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic check_idle_pins(string tag);
    chk({tag, "_cs"}, cs, 1'b1);
    chk({tag, "_sclk"}, sclk, 1'b0);
    chk({tag, "_mosi"}, mosi, 1'b0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((rsp_q.size() != 0 || bus.busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", longint'(rsp_q.size()), 0);
  endtask

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    longint t1, t2, tx;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_pins("reset");
    chk("reset_rsp_data", bus.rsp_data, 8'h00);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);
    reset = 1'b0;

    issue(1'b0, 3'd0, 8'hFF, 1'b0, tx);
    wait_drain();
    issue(1'b1, 3'd2, 8'h5A, 1'b0, tx);
    wait_drain();
    chk("periph_ch2", p_regs[2], 8'h5A);
    issue(1'b0, 3'd2, 8'hC3, 1'b0, tx);
    wait_drain();
    issue(1'b0, 3'd7, 8'h00, 1'b0, tx);
    wait_drain();
    issue(1'b1, 3'd7, 8'h33, 1'b0, tx);
    wait_drain();

    // cmd_valid held: second command must wait for the first rsp_valid cycle.
    issue(1'b1, 3'd3, 8'h11, 1'b1, t1);
    issue(1'b0, 3'd3, 8'h00, 1'b0, t2);
    chk("b2b_accept_gap", (t2 - t1) / T, WR_LAT + 1);
    wait_drain();

    // Abort a write at cycle 50 with reset.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 3'd1;
    bus.cmd_data  = 8'h77;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_pins("abort");
    reset = 1'b0;
    issue(1'b1, 3'd1, 8'h10, 1'b0, tx);
    wait_drain();
    chk("periph_ch1", p_regs[1], 8'h10);
    issue(1'b0, 3'd1, 8'h00, 1'b0, tx);
    wait_drain();

    for (int i = 0; i < 16; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, tx);
    end
    wait_drain();
    repeat (2 * D) @(negedge clk);
    chk("xfer_queue_empty", longint'(xfer_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
